rv32i_multicycle_controller: RTL and testbench
==============================================

# rv32i_multicycle_controller

Sequencing controller for the RV32I core, built as a multi-cycle state machine driving the same control signals as the single-cycle datapath. It adds PC and instruction-register enables, so the datapath shares one ALU pass per cycle and retires each instruction in 3–5 cycles. It decodes opcode, funct3 and funct7[5] from the instruction register. It traps on unsupported encodings.

## Interface
Parameters:
- none; all encodings are constants in the shared package.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- Op  in  7  Instr[6:0] from instruction register
- Funct3  in  3  Instr[14:12]
- Funct7  in  1  Instr[30]
- Z  in  1  ALU result zero
- IQF  in  1  ALU less-than flag (signed for SLT, unsigned for SLTU)
- IRWrite  out  1  latch instruction-memory output into IR
- PCWrite  out  1  PC register enable
- PCSrc  out  1  0: PC+4, 1: PC+ImmExt
- JALR  out  1  1: next PC = ALUResult with bit 0 cleared
- AUIPC  out  1  SrcA = PC instead of RD1
- ALUSrc  out  1  SrcB = ImmExt
- ImmSrc  out  3  I=000, S=001, B=010, U=011, J=100
- ALUControl  out  4  ALU operation
- ResultSrc  out  2  00 ALU, 01 ReadData, 10 PC+4, 11 ImmExt
- RegWrite  out  1  register-file write enable
- MemWrite  out  1  data-memory write enable
- Size  out  3  load/store width, equal to Funct3
- Instr_Done  out  1  one-cycle pulse on the retiring cycle
- Illegal  out  1  sticky trap flag
- State  out  4  current state, for debug display

## Operation
- States and codes:
  - FETCH 0
  - DECODE 1
  - EXEC_R 2
  - EXEC_I 3
  - ALU_WB 4
  - MEM_ADR 5
  - MEM_RD 6
  - MEM_WB 7
  - MEM_WR 8
  - BRANCH 9
  - JAL 10
  - JALR_S 11
  - UPPER 12
  - TRAP 15
- FETCH: IRWrite=1. Always goes to DECODE.
- DECODE dispatch on Op:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0000011 or 0100011 → MEM_ADR
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR_S
  - 0110111 or 0010111 → UPPER
  - anything else → TRAP
- EXEC_R / EXEC_I: ALUSrc=0 / 1. ALUControl comes from the decoder. Next state ALU_WB.
- ALU_WB: RegWrite=1, ResultSrc=00, PCWrite=1, PCSrc=0. Next FETCH.
- MEM_ADR:
  - ALUSrc=1, ALUControl=ADD.
  - ImmSrc is S for a store, I for a load.
  - Next MEM_WR (store) or MEM_RD (load).
- MEM_RD holds the address. Next MEM_WB.
- MEM_WB: RegWrite=1, ResultSrc=01, PCWrite=1. Next FETCH.
- MEM_WR: MemWrite=1, PCWrite=1. Next FETCH.
- BRANCH:
  - ImmSrc=B, PCWrite=1.
  - ALU=SUB for funct3 000/001, SLT for 100/101, SLTU for 110/111.
  - Taken conditions:
    - BEQ: Z
    - BNE: !Z
    - BLT/BLTU: IQF
    - BGE/BGEU: !IQF
  - PCSrc = taken. Next FETCH.
- JAL: ImmSrc=J, RegWrite=1, ResultSrc=10, PCWrite=1, PCSrc=1.
- JALR_S: ImmSrc=I, ALUSrc=1, ALU=ADD, JALR=1, RegWrite=1, ResultSrc=10, PCWrite=1.
- UPPER: ImmSrc=U, RegWrite=1, PCWrite=1.
  - LUI: ResultSrc=11.
  - AUIPC: AUIPC=1, ALUSrc=1, ALU=ADD, ResultSrc=00.
- ALU decode (EXEC_R and EXEC_I), by funct3:
  - 000: ADD, or SUB only when R-type and Funct7=1
  - 001: SLL
  - 010: SLT
  - 011: SLTU
  - 100: XOR
  - 101: SRL, or SRA when Funct7=1
  - 110: OR
  - 111: AND
- Illegal funct3 → TRAP, checked in DECODE:
  - load 011/110/111
  - store ≥011
  - branch 010/011
  - JALR ≠000
- TRAP: Illegal=1, all enables 0. Exit only by reset.
- Outputs not listed for a state are 0.

## Timing
- Moore outputs decode from the state register; Instr_Done is asserted in every state that asserts PCWrite.
- Cycles per instruction:
  - ALU register/immediate: 4
  - load: 5
  - store: 4
  - branch / JAL / JALR: 3
  - LUI / AUIPC: 3
- Reset:
  - State becomes FETCH on the reset edge.
  - While reset=1, RegWrite, MemWrite, PCWrite, IRWrite and Instr_Done are forced to 0 combinationally. This includes reset asserted mid-instruction, e.g. in MEM_WR.
  - Illegal clears on reset.
- Values after reset release: State=0, IRWrite=1, every other output 0.
- PCWrite and RegWrite in the same cycle are legal. JAL/JALR write PC+4 computed from the not-yet-updated PC.

## Structure
- Package rv32i_ctrl_pkg holds:
  - opcode constants
  - state encoding
  - ImmSrc / ResultSrc / ALUControl constants:
    - ADD 0000
    - SUB 0001
    - AND 0010
    - OR 0011
    - XOR 0100
    - SLL 0101
    - SRL 0110
    - SRA 0111
    - SLT 1000
    - SLTU 1001
- Combinational sub-module rv32i_alu_decoder: inputs Funct3, Funct7, R-type flag; output ALUControl.

## Test plan
- Reset held 3 cycles, released → State 0,1,2… sequence begins; IRWrite=1 only in cycle 0; no write enable pulses during reset.
- Op=0110011, Funct3=000, Funct7=1 → states 0,1,2,4; ALUControl=0001; RegWrite and PCWrite high in state 4 only; Instr_Done one pulse.
- Op=0000011, Funct3=010 → states 0,1,5,6,7; Size=010; ResultSrc=01 with RegWrite in state 7.
- Op=1100011, Funct3=001, Z=0 → BRANCH with PCSrc=1; repeat with Z=1 → PCSrc=0; Funct3=110 with IQF=1 → ALU=1001, PCSrc=1.
- Op=0100011 with reset asserted while State=8 → MemWrite stays 0; State=0 next cycle.
- Op=1111111 → TRAP (State=15), Illegal=1 and held for 10 cycles; reset clears it.

Source files
------------

// File: rtl/rv32i_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle controller: opcodes, FSM state codes,
// datapath mux selects and ALU operations, plus the funct3 legality rule.
package rv32i_ctrl_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_EXEC_R  = 4'd2,
      S_EXEC_I  = 4'd3,
      S_ALU_WB  = 4'd4,
      S_MEM_ADR = 4'd5,
      S_MEM_RD  = 4'd6,
      S_MEM_WB  = 4'd7,
      S_MEM_WR  = 4'd8,
      S_BRANCH  = 4'd9,
      S_JAL     = 4'd10,
      S_JALR    = 4'd11,
      S_UPPER   = 4'd12,
      S_TRAP    = 4'd15
   } state_e;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_U = 3'b011;
   localparam logic [2:0] IMM_J = 3'b100;

   localparam logic [1:0] RES_ALU  = 2'b00;
   localparam logic [1:0] RES_MEM  = 2'b01;
   localparam logic [1:0] RES_PC4  = 2'b10;
   localparam logic [1:0] RES_IMM  = 2'b11;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SLL  = 4'b0101;
   localparam logic [3:0] ALU_SRL  = 4'b0110;
   localparam logic [3:0] ALU_SRA  = 4'b0111;
   localparam logic [3:0] ALU_SLT  = 4'b1000;
   localparam logic [3:0] ALU_SLTU = 4'b1001;

   // Reserved funct3 values for loads, stores, branches and JALR trap in DECODE.
   function automatic logic funct3_legal(input logic [6:0] op, input logic [2:0] f3);
      logic ok;
      ok = 1'b1;
      case (op)
         OP_LOAD:   ok = !((f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111));
         OP_STORE:  ok = (f3 < 3'b011);
         OP_BRANCH: ok = !((f3 == 3'b010) || (f3 == 3'b011));
         OP_JALR:   ok = (f3 == 3'b000);
         default:   ok = 1'b1;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/rv32i_multicycle_controller_if.sv
// Control bundle between the multi-cycle controller (master) and the RV32I datapath (slave).
interface rv32i_multicycle_controller_if;

   logic [6:0] Op;
   logic [2:0] Funct3;
   logic       Funct7;
   logic       Z;
   logic       IQF;
   logic       IRWrite;
   logic       PCWrite;
   logic       PCSrc;
   logic       JALR;
   logic       AUIPC;
   logic       ALUSrc;
   logic [2:0] ImmSrc;
   logic [3:0] ALUControl;
   logic [1:0] ResultSrc;
   logic       RegWrite;
   logic       MemWrite;
   logic [2:0] Size;
   logic       Instr_Done;
   logic       Illegal;
   logic [3:0] State;

   modport master (
      input  Op, Funct3, Funct7, Z, IQF,
      output IRWrite, PCWrite, PCSrc, JALR, AUIPC, ALUSrc, ImmSrc, ALUControl,
             ResultSrc, RegWrite, MemWrite, Size, Instr_Done, Illegal, State
   );

   modport slave (
      output Op, Funct3, Funct7, Z, IQF,
      input  IRWrite, PCWrite, PCSrc, JALR, AUIPC, ALUSrc, ImmSrc, ALUControl,
             ResultSrc, RegWrite, MemWrite, Size, Instr_Done, Illegal, State
   );

endinterface

// File: rtl/rv32i_alu_decoder.sv
// Maps funct3/funct7[5] to an ALU operation for register and immediate ALU instructions.
module rv32i_alu_decoder
   import rv32i_ctrl_pkg::*;
(
   input  logic [2:0] i_funct3,
   input  logic       i_funct7,
   input  logic       i_rtype,
   output logic [3:0] o_alu_control
);

   // SUB exists only for R-type; for immediates bit 30 is part of the constant.
   always_comb begin
      o_alu_control = ALU_ADD;
      case (i_funct3)
         3'b000: begin
            if (i_rtype && i_funct7) o_alu_control = ALU_SUB;
            else                     o_alu_control = ALU_ADD;
         end
         3'b001: o_alu_control = ALU_SLL;
         3'b010: o_alu_control = ALU_SLT;
         3'b011: o_alu_control = ALU_SLTU;
         3'b100: o_alu_control = ALU_XOR;
         3'b101: begin
            if (i_funct7) o_alu_control = ALU_SRA;
            else          o_alu_control = ALU_SRL;
         end
         3'b110: o_alu_control = ALU_OR;
         3'b111: o_alu_control = ALU_AND;
         default: o_alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/rv32i_multicycle_controller.sv
// Multi-cycle sequencing FSM for RV32I: Moore control outputs decoded from the state
// register, with write enables forced low while reset is asserted.
module rv32i_multicycle_controller
   import rv32i_ctrl_pkg::*;
(
   input  logic                                clk,
   input  logic                                reset,
   rv32i_multicycle_controller_if.master      ctrl
);

   state_e     r_state;
   logic       r_illegal;
   state_e     w_dispatch;
   logic       w_rtype;
   logic [3:0] w_alu_dec;
   logic       w_taken;

   logic       w_irwrite;
   logic       w_pcwrite;
   logic       w_pcsrc;
   logic       w_jalr;
   logic       w_auipc;
   logic       w_alusrc;
   logic [2:0] w_immsrc;
   logic [3:0] w_alu;
   logic [1:0] w_resultsrc;
   logic       w_regwrite;
   logic       w_memwrite;

   assign w_rtype = (r_state == S_EXEC_R);

   rv32i_alu_decoder u_alu_dec (
      .i_funct3      (ctrl.Funct3),
      .i_funct7      (ctrl.Funct7),
      .i_rtype       (w_rtype),
      .o_alu_control (w_alu_dec)
   );

   // Opcode dispatch out of DECODE, including reserved-funct3 traps.
   always_comb begin
      w_dispatch = S_TRAP;
      case (ctrl.Op)
         OP_R:      w_dispatch = S_EXEC_R;
         OP_I:      w_dispatch = S_EXEC_I;
         OP_LOAD:   w_dispatch = S_MEM_ADR;
         OP_STORE:  w_dispatch = S_MEM_ADR;
         OP_BRANCH: w_dispatch = S_BRANCH;
         OP_JAL:    w_dispatch = S_JAL;
         OP_JALR:   w_dispatch = S_JALR;
         OP_LUI:    w_dispatch = S_UPPER;
         OP_AUIPC:  w_dispatch = S_UPPER;
         default:   w_dispatch = S_TRAP;
      endcase
      if (!funct3_legal(ctrl.Op, ctrl.Funct3)) w_dispatch = S_TRAP;
      else                                     w_dispatch = w_dispatch;
   end

   // Branch resolution from the compare flags of this cycle's ALU pass.
   always_comb begin
      w_taken = 1'b0;
      case (ctrl.Funct3)
         3'b000:  w_taken = ctrl.Z;
         3'b001:  w_taken = !ctrl.Z;
         3'b100:  w_taken = ctrl.IQF;
         3'b110:  w_taken = ctrl.IQF;
         3'b101:  w_taken = !ctrl.IQF;
         3'b111:  w_taken = !ctrl.IQF;
         default: w_taken = 1'b0;
      endcase
   end

   // State register and sticky trap flag; TRAP is left only through reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_FETCH;
         r_illegal <= 1'b0;
      end else begin
         case (r_state)
            S_FETCH:   r_state <= S_DECODE;
            S_DECODE: begin
               r_state <= w_dispatch;
               if (w_dispatch == S_TRAP) r_illegal <= 1'b1;
            end
            S_EXEC_R:  r_state <= S_ALU_WB;
            S_EXEC_I:  r_state <= S_ALU_WB;
            S_ALU_WB:  r_state <= S_FETCH;
            S_MEM_ADR: r_state <= (ctrl.Op == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:  r_state <= S_MEM_WB;
            S_MEM_WB:  r_state <= S_FETCH;
            S_MEM_WR:  r_state <= S_FETCH;
            S_BRANCH:  r_state <= S_FETCH;
            S_JAL:     r_state <= S_FETCH;
            S_JALR:    r_state <= S_FETCH;
            S_UPPER:   r_state <= S_FETCH;
            S_TRAP:    r_state <= S_TRAP;
            default: begin
               r_state   <= S_TRAP;
               r_illegal <= 1'b1;
            end
         endcase
      end
   end

   // Per-state control decode; anything not set for a state stays 0.
   always_comb begin
      w_irwrite   = 1'b0;
      w_pcwrite   = 1'b0;
      w_pcsrc     = 1'b0;
      w_jalr      = 1'b0;
      w_auipc     = 1'b0;
      w_alusrc    = 1'b0;
      w_immsrc    = IMM_I;
      w_alu       = ALU_ADD;
      w_resultsrc = RES_ALU;
      w_regwrite  = 1'b0;
      w_memwrite  = 1'b0;
      case (r_state)
         S_FETCH:  w_irwrite = 1'b1;
         S_EXEC_R: w_alu = w_alu_dec;
         S_EXEC_I: begin
            w_alusrc = 1'b1;
            w_alu    = w_alu_dec;
         end
         S_ALU_WB: begin
            w_regwrite = 1'b1;
            w_pcwrite  = 1'b1;
         end
         S_MEM_ADR: begin
            w_alusrc = 1'b1;
            w_immsrc = (ctrl.Op == OP_STORE) ? IMM_S : IMM_I;
         end
         S_MEM_WB: begin
            w_regwrite  = 1'b1;
            w_resultsrc = RES_MEM;
            w_pcwrite   = 1'b1;
         end
         S_MEM_WR: begin
            w_memwrite = 1'b1;
            w_pcwrite  = 1'b1;
         end
         S_BRANCH: begin
            w_immsrc  = IMM_B;
            w_pcwrite = 1'b1;
            w_pcsrc   = w_taken;
            if (!ctrl.Funct3[2])     w_alu = ALU_SUB;
            else if (ctrl.Funct3[1]) w_alu = ALU_SLTU;
            else                     w_alu = ALU_SLT;
         end
         S_JAL: begin
            w_immsrc    = IMM_J;
            w_regwrite  = 1'b1;
            w_resultsrc = RES_PC4;
            w_pcwrite   = 1'b1;
            w_pcsrc     = 1'b1;
         end
         S_JALR: begin
            w_alusrc    = 1'b1;
            w_jalr      = 1'b1;
            w_regwrite  = 1'b1;
            w_resultsrc = RES_PC4;
            w_pcwrite   = 1'b1;
         end
         S_UPPER: begin
            w_immsrc   = IMM_U;
            w_regwrite = 1'b1;
            w_pcwrite  = 1'b1;
            if (ctrl.Op == OP_AUIPC) begin
               w_auipc     = 1'b1;
               w_alusrc    = 1'b1;
               w_resultsrc = RES_ALU;
            end else begin
               w_resultsrc = RES_IMM;
            end
         end
         default: w_irwrite = 1'b0;
      endcase
   end

   assign ctrl.IRWrite    = w_irwrite  & ~reset;
   assign ctrl.PCWrite    = w_pcwrite  & ~reset;
   assign ctrl.RegWrite   = w_regwrite & ~reset;
   assign ctrl.MemWrite   = w_memwrite & ~reset;
   assign ctrl.Instr_Done = w_pcwrite  & ~reset;
   assign ctrl.PCSrc      = w_pcsrc;
   assign ctrl.JALR       = w_jalr;
   assign ctrl.AUIPC      = w_auipc;
   assign ctrl.ALUSrc     = w_alusrc;
   assign ctrl.ImmSrc     = w_immsrc;
   assign ctrl.ALUControl = w_alu;
   assign ctrl.ResultSrc  = w_resultsrc;
   assign ctrl.Size       = ctrl.Funct3;
   assign ctrl.Illegal    = r_illegal;
   assign ctrl.State      = r_state;

endmodule

// File: tb/tb_rv32i_multicycle_controller.sv
// Scoreboard bench: the driver pushes a per-instruction expectation from a reference
// model; a negedge monitor compares execute-cycle and retire-cycle outputs.
module tb_rv32i_multicycle_controller;

   typedef struct packed {
      logic            trap;
      logic [3:0]      cycles;
      logic [4:0][3:0] st;
      logic [2:0]      f3;
      logic [3:0]      x_alu;
      logic            x_alusrc;
      logic [2:0]      x_imm;
      logic            x_jalr;
      logic            x_auipc;
      logic            r_regw;
      logic            r_memw;
      logic [1:0]      r_rsrc;
      logic            r_pcsrc;
   } exp_t;

   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;
   int   k;
   exp_t sb_q[$];

   rv32i_multicycle_controller_if ctrl();

   rv32i_multicycle_controller dut (
      .clk   (clk),
      .reset (reset),
      .ctrl  (ctrl)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ALU operation table for register/immediate instructions
   function automatic logic [3:0] alu_ref(input logic [2:0] f3, input logic f7, input logic rtype);
      logic [3:0] tab [8];
      tab[0] = 4'd0; tab[1] = 4'd5; tab[2] = 4'd8; tab[3] = 4'd9;
      tab[4] = 4'd4; tab[5] = 4'd6; tab[6] = 4'd3; tab[7] = 4'd2;
      if (f3 == 3'd0 && rtype && f7) return 4'd1;
      if (f3 == 3'd5 && f7) return 4'd7;
      return tab[f3];
   endfunction

   function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                  input logic z, input logic iqf);
      exp_t e;
      e = '0;
      e.f3 = f3;
      e.st[0] = 4'd0;
      e.st[1] = 4'd1;
      case (op)
         7'b0110011: begin
            e.cycles = 4'd4; e.st[2] = 4'd2; e.st[3] = 4'd4;
            e.x_alu = alu_ref(f3, f7, 1'b1); e.r_regw = 1'b1;
         end
         7'b0010011: begin
            e.cycles = 4'd4; e.st[2] = 4'd3; e.st[3] = 4'd4;
            e.x_alu = alu_ref(f3, f7, 1'b0); e.x_alusrc = 1'b1; e.r_regw = 1'b1;
         end
         7'b0000011: begin
            if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) e.trap = 1'b1;
            e.cycles = 4'd5; e.st[2] = 4'd5; e.st[3] = 4'd6; e.st[4] = 4'd7;
            e.x_alusrc = 1'b1; e.r_regw = 1'b1; e.r_rsrc = 2'd1;
         end
         7'b0100011: begin
            if (f3 >= 3'd3) e.trap = 1'b1;
            e.cycles = 4'd4; e.st[2] = 4'd5; e.st[3] = 4'd8;
            e.x_alusrc = 1'b1; e.x_imm = 3'd1; e.r_memw = 1'b1;
         end
         7'b1100011: begin
            if (f3 == 3'd2 || f3 == 3'd3) e.trap = 1'b1;
            e.cycles = 4'd3; e.st[2] = 4'd9; e.x_imm = 3'd2;
            if (f3 < 3'd2)       e.x_alu = 4'd1;
            else if (f3 < 3'd6)  e.x_alu = 4'd8;
            else                 e.x_alu = 4'd9;
            case (f3)
               3'd0:    e.r_pcsrc = z;
               3'd1:    e.r_pcsrc = !z;
               3'd4, 3'd6: e.r_pcsrc = iqf;
               default: e.r_pcsrc = !iqf;
            endcase
         end
         7'b1101111: begin
            e.cycles = 4'd3; e.st[2] = 4'd10; e.x_imm = 3'd4;
            e.r_regw = 1'b1; e.r_rsrc = 2'd2; e.r_pcsrc = 1'b1;
         end
         7'b1100111: begin
            if (f3 != 3'd0) e.trap = 1'b1;
            e.cycles = 4'd3; e.st[2] = 4'd11; e.x_alusrc = 1'b1; e.x_jalr = 1'b1;
            e.r_regw = 1'b1; e.r_rsrc = 2'd2;
         end
         7'b0110111: begin
            e.cycles = 4'd3; e.st[2] = 4'd12; e.x_imm = 3'd3; e.r_regw = 1'b1; e.r_rsrc = 2'd3;
         end
         7'b0010111: begin
            e.cycles = 4'd3; e.st[2] = 4'd12; e.x_imm = 3'd3; e.x_auipc = 1'b1;
            e.x_alusrc = 1'b1; e.r_regw = 1'b1;
         end
         default: e.trap = 1'b1;
      endcase
      return e;
   endfunction

   // Monitor: per-cycle enable sanity, execute-cycle outputs, and retire-cycle outputs.
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         k = 0;
      end else begin
         check("irwrite_only_fetch", ctrl.IRWrite, (k == 0));
         if (k == 2 && sb_q.size() != 0) begin
            e = sb_q[0];
            check("exec_alu", ctrl.ALUControl, e.x_alu);
            check("exec_alusrc", ctrl.ALUSrc, e.x_alusrc);
            check("exec_immsrc", ctrl.ImmSrc, e.x_imm);
            check("exec_jalr", ctrl.JALR, e.x_jalr);
            check("exec_auipc", ctrl.AUIPC, e.x_auipc);
            check("exec_size", ctrl.Size, e.f3);
         end
         if (ctrl.Instr_Done) begin
            if (sb_q.size() == 0) begin
               check("unexpected_retire", ctrl.Instr_Done, 1'b0);
            end else begin
               e = sb_q.pop_front();
               check("cpi", k + 1, e.cycles);
               check("ret_pcwrite", ctrl.PCWrite, 1'b1);
               check("ret_regwrite", ctrl.RegWrite, e.r_regw);
               check("ret_memwrite", ctrl.MemWrite, e.r_memw);
               check("ret_resultsrc", ctrl.ResultSrc, e.r_rsrc);
               check("ret_pcsrc", ctrl.PCSrc, e.r_pcsrc);
            end
            k = 0;
         end else begin
            check("idle_enables", {ctrl.PCWrite, ctrl.RegWrite, ctrl.MemWrite}, 3'b000);
            k++;
         end
      end
   end

   task automatic pulse_reset();
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
   endtask

   // Entered at posedge+1 with the DUT in FETCH; returns the same way.
   task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                            input logic z, input logic iqf);
      exp_t e;
      int   n;
      e = model(op, f3, f7, z, iqf);
      ctrl.Op = op; ctrl.Funct3 = f3; ctrl.Funct7 = f7; ctrl.Z = z; ctrl.IQF = iqf;
      if (e.trap) begin
         @(negedge clk);
         @(negedge clk);
         check("pre_trap_illegal", ctrl.Illegal, 1'b0);
         @(negedge clk);
         check("trap_state", ctrl.State, 4'd15);
         check("trap_illegal", ctrl.Illegal, 1'b1);
         repeat (10) @(negedge clk);
         check("trap_held_state", ctrl.State, 4'd15);
         check("trap_held_illegal", ctrl.Illegal, 1'b1);
         pulse_reset();
         #1;
         check("trap_cleared", ctrl.Illegal, 1'b0);
         check("trap_reset_state", ctrl.State, 4'd0);
      end else begin
         sb_q.push_back(e);
         n = 0;
         do begin
            @(negedge clk);
            if (n < 5 && n < int'(e.cycles)) check("state_seq", ctrl.State, e.st[n]);
            n++;
         end while (!ctrl.Instr_Done && n < 8);
         if (!ctrl.Instr_Done) begin
            n_tests++;
            n_fail++;
            $display("FAIL retire_timeout: got no Instr_Done in %0d cycles, required %0d", n, e.cycles);
            sb_q.delete();
            pulse_reset();
         end else begin
            @(posedge clk); #1;
         end
      end
   endtask

   logic [6:0] legal_ops [9];

   initial begin
      legal_ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                    7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
      n_tests = 0; n_fail = 0; k = 0;
      reset = 1'b1;
      ctrl.Op = 7'b0110011; ctrl.Funct3 = 3'd0; ctrl.Funct7 = 1'b1; ctrl.Z = 1'b0; ctrl.IQF = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("rst_enables", {ctrl.RegWrite, ctrl.MemWrite, ctrl.PCWrite, ctrl.IRWrite,
                               ctrl.Instr_Done}, 5'b00000);
         check("rst_state", ctrl.State, 4'd0);
      end
      @(posedge clk); #1 reset = 1'b0;
      #1;
      check("post_rst_state", ctrl.State, 4'd0);
      check("post_rst_irwrite", ctrl.IRWrite, 1'b1);
      check("post_rst_others", {ctrl.PCWrite, ctrl.PCSrc, ctrl.JALR, ctrl.AUIPC, ctrl.ALUSrc,
                                ctrl.ImmSrc, ctrl.ALUControl, ctrl.ResultSrc, ctrl.RegWrite,
                                ctrl.MemWrite, ctrl.Size, ctrl.Instr_Done, ctrl.Illegal}, 32'd0);

      run_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0);
      run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0);
      run_instr(7'b1100011, 3'b001, 1'b0, 1'b0, 1'b0);
      run_instr(7'b1100011, 3'b001, 1'b0, 1'b1, 1'b0);
      run_instr(7'b1100011, 3'b110, 1'b0, 1'b0, 1'b1);
      run_instr(7'b0010011, 3'b101, 1'b1, 1'b0, 1'b0);
      run_instr(7'b0110111, 3'b011, 1'b0, 1'b0, 1'b0);
      run_instr(7'b0010111, 3'b000, 1'b0, 1'b0, 1'b0);

      // Reset arriving while the store is in its write cycle must suppress MemWrite.
      ctrl.Op = 7'b0100011; ctrl.Funct3 = 3'b010; ctrl.Funct7 = 1'b0;
      repeat (3) @(negedge clk);
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk);
      check("midrst_state", ctrl.State, 4'd8);
      check("midrst_memwrite", ctrl.MemWrite, 1'b0);
      check("midrst_pcwrite", {ctrl.PCWrite, ctrl.Instr_Done}, 2'b00);
      @(posedge clk); #1 reset = 1'b0;
      #1;
      check("midrst_next_state", ctrl.State, 4'd0);
      check("midrst_irwrite", ctrl.IRWrite, 1'b1);

      run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0);
      run_instr(7'b0100011, 3'b011, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 80; i++) begin
         logic [6:0] op;
         if ($urandom_range(0, 9) == 0) op = 7'($urandom);
         else                           op = legal_ops[$urandom_range(0, 8)];
         run_instr(op, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      end

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
